// File: rtl/redirect_hazard_unit_if.sv
// Pipeline-facing bundle for the EX-stage redirect/hazard unit.
// slave: the unit itself. master: whatever drives the pipeline side.
interface redirect_hazard_unit_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  // ID-stage sources, used only for load-use detection
  logic [REG_AW-1:0] rs_id;
  logic [REG_AW-1:0] rt_id;
  logic              rs_valid_id;
  logic              rt_valid_id;
  // EX-stage operands straight from the ID/EX register
  logic [REG_AW-1:0] rA_ex;
  logic [REG_AW-1:0] rB_ex;
  logic              rB_valid_ex;
  logic [DATA_W-1:0] RA_ex;
  logic [DATA_W-1:0] RB_ex;
  logic [REG_AW-1:0] rW_ex;
  logic              rW_en_ex;
  logic              mem_read_ex;
  // Later-stage producers
  logic [REG_AW-1:0] rW_mem;
  logic              rW_en_mem;
  logic [DATA_W-1:0] result_mem;
  logic [REG_AW-1:0] rW_wb;
  logic              rW_en_wb;
  logic [DATA_W-1:0] result_wb;
  // Control
  logic              flush;
  logic              cnt_clr;
  // Results
  logic [DATA_W-1:0] nRA;
  logic [DATA_W-1:0] nRB;
  logic              stall;
  logic              bubble;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  fwd_cnt;

  modport slave (
    input  rs_id, rt_id, rs_valid_id, rt_valid_id,
    input  rA_ex, rB_ex, rB_valid_ex, RA_ex, RB_ex,
    input  rW_ex, rW_en_ex, mem_read_ex,
    input  rW_mem, rW_en_mem, result_mem,
    input  rW_wb, rW_en_wb, result_wb,
    input  flush, cnt_clr,
    output nRA, nRB, stall, bubble, stall_cnt, fwd_cnt
  );

  modport master (
    output rs_id, rt_id, rs_valid_id, rt_valid_id,
    output rA_ex, rB_ex, rB_valid_ex, RA_ex, RB_ex,
    output rW_ex, rW_en_ex, mem_read_ex,
    output rW_mem, rW_en_mem, result_mem,
    output rW_wb, rW_en_wb, result_wb,
    output flush, cnt_clr,
    input  nRA, nRB, stall, bubble, stall_cnt, fwd_cnt
  );
endinterface

// File: rtl/redirect_hazard_unit.sv
// EX-stage operand forwarding (MEM > WB > WB-hold > regfile), load-use
// stall FSM driving the PC/IF-ID freeze and ID/EX bubble, and saturating
// stall / forward event counters.
module redirect_hazard_unit #(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 5,
  parameter int HOLD_EN   = 1,
  parameter int STALL_CYC = 1,
  parameter int CNT_W     = 32
) (
  input logic                   clk,
  input logic                   rst_n,
  redirect_hazard_unit_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, STALL = 1'b1} state_t;

  state_t            state;
  logic              scnt;

  logic              hold_vld;
  logic [REG_AW-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;

  logic              mem_a, wb_a, hold_a, fwd_a;
  logic              mem_b, wb_b, hold_b, fwd_b;
  logic [DATA_W-1:0] nra, nrb;
  logic [1:0]        fwd_num;
  logic              hz;
  logic              stall_c;

  logic [CNT_W-1:0]  stall_cnt_q, fwd_cnt_q;
  logic [CNT_W:0]    stall_sum, fwd_sum;

  // Source match per stage; register 0 never matches so $0 reads stay zero.
  always_comb begin
    mem_a  = bus.rW_en_mem && (bus.rW_mem == bus.rA_ex) && (bus.rA_ex != '0);
    wb_a   = bus.rW_en_wb  && (bus.rW_wb  == bus.rA_ex) && (bus.rA_ex != '0);
    hold_a = (HOLD_EN != 0) && hold_vld && (hold_addr == bus.rA_ex) && (bus.rA_ex != '0);
    mem_b  = bus.rB_valid_ex && bus.rW_en_mem && (bus.rW_mem == bus.rB_ex) && (bus.rB_ex != '0);
    wb_b   = bus.rB_valid_ex && bus.rW_en_wb  && (bus.rW_wb  == bus.rB_ex) && (bus.rB_ex != '0);
    hold_b = bus.rB_valid_ex && (HOLD_EN != 0) && hold_vld &&
             (hold_addr == bus.rB_ex) && (bus.rB_ex != '0);
    fwd_a  = mem_a || wb_a || hold_a;
    fwd_b  = mem_b || wb_b || hold_b;
    fwd_num = {1'b0, fwd_a} + {1'b0, fwd_b};
  end

  // Priority operand muxes: youngest producer wins.
  always_comb begin
    if (mem_a)       nra = bus.result_mem;
    else if (wb_a)   nra = bus.result_wb;
    else if (hold_a) nra = hold_data;
    else             nra = bus.RA_ex;
    if (mem_b)       nrb = bus.result_mem;
    else if (wb_b)   nrb = bus.result_wb;
    else if (hold_b) nrb = hold_data;
    else             nrb = bus.RB_ex;
  end

  // One-cycle copy of the WB write, covering a regfile without write-through.
  generate
    if (HOLD_EN != 0) begin : g_hold
      // Capture every WB write for exactly one cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hold_vld  <= 1'b0;
          hold_addr <= '0;
          hold_data <= '0;
        end else begin
          hold_vld  <= bus.rW_en_wb && (bus.rW_wb != '0);
          hold_addr <= bus.rW_wb;
          hold_data <= bus.result_wb;
        end
      end
    end else begin : g_nohold
      assign hold_vld  = 1'b0;
      assign hold_addr = '0;
      assign hold_data = '0;
    end
  endgenerate

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    hz = bus.mem_read_ex && bus.rW_en_ex && (bus.rW_ex != '0) &&
         ((bus.rs_valid_id && (bus.rs_id == bus.rW_ex)) ||
          (bus.rt_valid_id && (bus.rt_id == bus.rW_ex)));
  end

  // First stall cycle comes straight from detection; a STALL state only
  // extends it. Reset and flush both drop it immediately.
  always_comb begin
    stall_c = rst_n && !bus.flush && ((state == STALL) || hz);
  end

  // Stall sequencer: IDLE only leaves when a second stall cycle is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      scnt  <= 1'b0;
    end else if (bus.flush) begin
      state <= IDLE;
      scnt  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hz && (STALL_CYC == 2)) begin
            state <= STALL;
            scnt  <= 1'b1;
          end
        end
        STALL: begin
          scnt <= scnt - 1'b1;
          if (scnt == 1'b1) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          scnt  <= 1'b0;
        end
      endcase
    end
  end

  // Widened sums so the carry-out flags saturation.
  always_comb begin
    stall_sum = {1'b0, stall_cnt_q} + {{CNT_W{1'b0}}, stall_c};
    fwd_sum   = {1'b0, fwd_cnt_q} + {{(CNT_W-1){1'b0}}, fwd_num};
  end

  // Saturating event counters; clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else if (bus.cnt_clr) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_sum[CNT_W] ? {CNT_W{1'b1}} : stall_sum[CNT_W-1:0];
      fwd_cnt_q   <= fwd_sum[CNT_W]   ? {CNT_W{1'b1}} : fwd_sum[CNT_W-1:0];
    end
  end

  assign bus.nRA       = nra;
  assign bus.nRB       = nrb;
  assign bus.stall     = stall_c;
  assign bus.bubble    = stall_c;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.fwd_cnt   = fwd_cnt_q;

endmodule

// File: tb/tb_redirect_hazard_unit.sv
// Directed bench: dut_a (HOLD_EN=1, STALL_CYC=1) and dut_b (HOLD_EN=0,
// STALL_CYC=2) see identical pipeline inputs; 4-bit counters make
// saturation reachable.
module tb_redirect_hazard_unit;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  redirect_hazard_unit_if #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) ifa ();
  redirect_hazard_unit_if #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) ifb ();

  redirect_hazard_unit #(.DATA_W(DW), .REG_AW(AW), .HOLD_EN(1), .STALL_CYC(1), .CNT_W(CW))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  redirect_hazard_unit #(.DATA_W(DW), .REG_AW(AW), .HOLD_EN(0), .STALL_CYC(2), .CNT_W(CW))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  assign ifb.rs_id       = ifa.rs_id;
  assign ifb.rt_id       = ifa.rt_id;
  assign ifb.rs_valid_id = ifa.rs_valid_id;
  assign ifb.rt_valid_id = ifa.rt_valid_id;
  assign ifb.rA_ex       = ifa.rA_ex;
  assign ifb.rB_ex       = ifa.rB_ex;
  assign ifb.rB_valid_ex = ifa.rB_valid_ex;
  assign ifb.RA_ex       = ifa.RA_ex;
  assign ifb.RB_ex       = ifa.RB_ex;
  assign ifb.rW_ex       = ifa.rW_ex;
  assign ifb.rW_en_ex    = ifa.rW_en_ex;
  assign ifb.mem_read_ex = ifa.mem_read_ex;
  assign ifb.rW_mem      = ifa.rW_mem;
  assign ifb.rW_en_mem   = ifa.rW_en_mem;
  assign ifb.result_mem  = ifa.result_mem;
  assign ifb.rW_wb       = ifa.rW_wb;
  assign ifb.rW_en_wb    = ifa.rW_en_wb;
  assign ifb.result_wb   = ifa.result_wb;
  assign ifb.flush       = ifa.flush;
  assign ifb.cnt_clr     = ifa.cnt_clr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    ifa.rs_id = '0;       ifa.rt_id = '0;
    ifa.rs_valid_id = 0;  ifa.rt_valid_id = 0;
    ifa.rA_ex = '0;       ifa.rB_ex = '0;       ifa.rB_valid_ex = 0;
    ifa.RA_ex = 32'hA0A0; ifa.RB_ex = 32'hB0B0;
    ifa.rW_ex = '0;       ifa.rW_en_ex = 0;     ifa.mem_read_ex = 0;
    ifa.rW_mem = '0;      ifa.rW_en_mem = 0;    ifa.result_mem = '0;
    ifa.rW_wb = '0;       ifa.rW_en_wb = 0;     ifa.result_wb = '0;
    ifa.flush = 0;        ifa.cnt_clr = 0;
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_hazard();
    ifa.mem_read_ex = 1; ifa.rW_en_ex = 1; ifa.rW_ex = 5;
    ifa.rs_id = 5;       ifa.rs_valid_id = 1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 0;
    idle_in();
    ifa.RA_ex = 32'h11;
    #12;
    chk("rst_stall_a", {31'b0, ifa.stall}, 0);
    chk("rst_bubble_b", {31'b0, ifb.bubble}, 0);
    chk("rst_stall_cnt", {28'b0, ifa.stall_cnt}, 0);
    chk("rst_fwd_cnt", {28'b0, ifb.fwd_cnt}, 0);
    chk("rst_nra_pass", ifa.nRA, 32'h11);
    rst_n = 1;
    idle_in();
    step();

    // MEM beats WB on both operands
    ifa.rA_ex = 3; ifa.rB_ex = 3; ifa.rB_valid_ex = 1;
    ifa.rW_mem = 3; ifa.rW_en_mem = 1; ifa.result_mem = 32'hAAAA0000;
    ifa.rW_wb = 3;  ifa.rW_en_wb = 1;  ifa.result_wb = 32'h5555;
    #1;
    chk("mem_wins_a", ifa.nRA, 32'hAAAA0000);
    chk("mem_wins_b", ifa.nRB, 32'hAAAA0000);
    step();
    chk("fwd_cnt_plus2", {28'b0, ifa.fwd_cnt}, 2);

    // WB beats hold (hold now carries r3=0x5555)
    ifa.rW_en_mem = 0; ifa.result_wb = 32'h6666;
    #1;
    chk("wb_over_hold", ifa.nRA, 32'h6666);
    step();
    chk("fwd_cnt_4", {28'b0, ifa.fwd_cnt}, 4);

    // $0 never forwards; rB match ignored when rB not read
    idle_in();
    ifa.rA_ex = 0; ifa.RA_ex = 0; ifa.rW_mem = 0; ifa.rW_en_mem = 1; ifa.result_mem = 32'hDEAD;
    ifa.rB_ex = 4; ifa.rB_valid_ex = 0; ifa.rW_wb = 4; ifa.rW_en_wb = 1; ifa.result_wb = 32'h77;
    #1;
    chk("zero_reg_a", ifa.nRA, 0);
    chk("rb_invalid", ifa.nRB, 32'hB0B0);
    step();
    chk("fwd_cnt_no_fwd", {28'b0, ifa.fwd_cnt}, 4);

    // Hold buffer: WB writes r7 at n, visible at n+1 only
    idle_in();
    ifa.rW_wb = 7; ifa.rW_en_wb = 1; ifa.result_wb = 32'h1234;
    step();
    idle_in();
    ifa.rA_ex = 7;
    #1;
    chk("hold_fwd_a", ifa.nRA, 32'h1234);
    chk("hold_off_b", ifb.nRA, 32'hA0A0);
    step();
    chk("hold_expired", ifa.nRA, 32'hA0A0);
    chk("fwd_cnt_hold_a", {28'b0, ifa.fwd_cnt}, 5);
    chk("fwd_cnt_hold_b", {28'b0, ifb.fwd_cnt}, 4);

    // Load-use stall
    idle_in();
    load_hazard();
    #1;
    chk("lu_stall_a", {31'b0, ifa.stall}, 1);
    chk("lu_bubble_a", {31'b0, ifa.bubble}, 1);
    chk("lu_stall_b", {31'b0, ifb.stall}, 1);
    step();
    chk("lu_stall_cnt_a", {28'b0, ifa.stall_cnt}, 1);
    idle_in();
    ifa.rA_ex = 5; ifa.rW_mem = 5; ifa.rW_en_mem = 1; ifa.result_mem = 32'hC0DE;
    #1;
    chk("lu_release_a", {31'b0, ifa.stall}, 0);
    chk("lu_fwd_mem", ifa.nRA, 32'hC0DE);
    chk("lu_second_b", {31'b0, ifb.stall}, 1);
    step();
    chk("lu_stall_cnt_b", {28'b0, ifb.stall_cnt}, 2);
    chk("lu_fwd_cnt_a", {28'b0, ifa.fwd_cnt}, 6);
    idle_in();
    #1;
    chk("lu_done_b", {31'b0, ifb.stall}, 0);
    step();

    // Flush during a 2-cycle stall; flush also beats a live hazard
    load_hazard();
    step();
    ifa.flush = 1;
    #1;
    chk("flush_b", {31'b0, ifb.stall}, 0);
    chk("flush_over_hz_a", {31'b0, ifa.stall}, 0);
    step();
    idle_in();
    #1;
    chk("flush_idle_b", {31'b0, ifb.stall}, 0);
    chk("flush_cnt_a", {28'b0, ifa.stall_cnt}, 2);
    chk("flush_cnt_b", {28'b0, ifb.stall_cnt}, 3);

    // Saturation: a at 6, b at 5, +2 per cycle for 6 cycles
    ifa.rA_ex = 3; ifa.rB_ex = 3; ifa.rB_valid_ex = 1;
    ifa.rW_mem = 3; ifa.rW_en_mem = 1; ifa.result_mem = 32'h9;
    for (int i = 0; i < 6; i++) step();
    chk("sat_fwd_a", {28'b0, ifa.fwd_cnt}, 15);
    chk("sat_fwd_b", {28'b0, ifb.fwd_cnt}, 15);
    ifa.cnt_clr = 1;
    step();
    chk("clr_fwd_a", {28'b0, ifa.fwd_cnt}, 0);
    chk("clr_stall_b", {28'b0, ifb.stall_cnt}, 0);

    // Async reset mid-stall
    idle_in();
    load_hazard();
    step();
    chk("pre_rst_cnt_b", {28'b0, ifb.stall_cnt}, 1);
    idle_in();
    #1;
    chk("pre_rst_stall_b", {31'b0, ifb.stall}, 1);
    rst_n = 0;
    #1;
    chk("rst_mid_stall_b", {31'b0, ifb.stall}, 0);
    chk("rst_mid_cnt_b", {28'b0, ifb.stall_cnt}, 0);
    chk("rst_mid_cnt_a", {28'b0, ifa.stall_cnt}, 0);
    rst_n = 1;
    step();
    chk("post_rst_idle_b", {31'b0, ifb.stall}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
